// File: rtl/clk_ctrl_pkg.sv
// Shared constants and state encoding for the CPU clock controller.
// The state values are visible on O_STATE, so their encoding is fixed.
package clk_ctrl_pkg;

  localparam int CLK_CNT_W   = 32;
  localparam int CLK_DEF_DIV = 4;
  localparam int CLK_CYC_W   = 32;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Programmable half-period divider: holds the ratio, counts I_CLK cycles,
// toggles the divided clock and flags the rising/falling toggle edges.
module clk_div_core
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W   = CLK_CNT_W,
  parameter int DEF_DIV = CLK_DEF_DIV
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             clk_out,
  output logic             clk_en,
  output logic             rise_tick,
  output logic             fall_tick
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = (DEF_DIV == 0) ? CNT_W'(1) : CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic             clk_reg, clk_next;
  logic             en_reg;
  logic             terminal;
  logic             run_ok;

  // A ratio of zero would never reach terminal count, so it is clamped to 1.
  always_comb begin
    terminal  = (cnt_reg == (div_reg - CNT_ONE));
    run_ok    = enable && !restart;
    rise_tick = run_ok && terminal && !clk_reg;
    fall_tick = run_ok && terminal && clk_reg;
    div_next  = div_reg;
    if (load) begin
      div_next = (load_div == '0) ? CNT_ONE : load_div;
    end
    cnt_next = '0;
    clk_next = 1'b0;
    if (run_ok) begin
      if (terminal) begin
        cnt_next = '0;
        clk_next = ~clk_reg;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
        clk_next = clk_reg;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      div_reg <= DIV_RST;
      clk_reg <= 1'b0;
      en_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      div_reg <= div_next;
      clk_reg <= clk_next;
      en_reg  <= rise_tick;
    end
  end

  assign clk_out = clk_reg;
  assign clk_en  = en_reg;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller for the CPU clock. The divided clock
// always stops low; the ratio can only change while halted.
module cpu_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W   = CLK_CNT_W,
  parameter int DEF_DIV = CLK_DEF_DIV,
  parameter int CYC_W   = CLK_CYC_W
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             O_CLK,
  output logic             O_CLK_EN,
  output logic [1:0]       O_STATE,
  output logic [CYC_W-1:0] O_CYCLES
);

  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  state_t           state_reg, state_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic             restart;
  logic             cfg_load;
  logic             div_enable;
  logic             rise_tick;
  logic             fall_tick;

  assign cfg_ready  = (state_reg == ST_HALT);
  assign cfg_load   = cfg_valid && cfg_ready;
  assign div_enable = (state_reg != ST_HALT);

  clk_div_core #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) u_div (
    .I_CLK     (I_CLK),
    .rst       (rst),
    .enable    (div_enable),
    .restart   (restart),
    .load      (cfg_load),
    .load_div  (cfg_div),
    .clk_out   (O_CLK),
    .clk_en    (O_CLK_EN),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // In STEP the falling edge wins over a late halt_req so at most one rise is issued.
  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    case (state_reg)
      ST_HALT: begin
        if (step_req) begin
          state_next = ST_STEP;
          restart    = 1'b1;
        end else if (run_req) begin
          state_next = ST_RUN;
          restart    = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) state_next = ST_DRAIN;
      end
      ST_STEP: begin
        if (fall_tick)     state_next = ST_HALT;
        else if (halt_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fall_tick) state_next = ST_HALT;
      end
      default: state_next = ST_HALT;
    endcase
  end

  always_comb begin
    cyc_next = cyc_reg;
    if (rise_tick) cyc_next = cyc_reg + CYC_ONE;
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_HALT;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
    end
  end

  assign O_STATE  = state_reg;
  assign O_CYCLES = cyc_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scenario bench for cpu_clk_ctrl with a phase-arithmetic reference model.
// The model tracks edges since start and derives clock level from t mod 2*div.
module tb_cpu_clk_ctrl;

  logic        I_CLK;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic        O_CLK;
  logic        O_CLK_EN;
  logic [1:0]  O_STATE;
  logic [3:0]  O_CYCLES;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 halt, 1 run, 2 step, 3 drain
  int m_mode, m_div, m_t, m_stop, m_cycles;
  logic e_clk, e_en;

  cpu_clk_ctrl #(.CNT_W(32), .DEF_DIV(4), .CYC_W(4)) dut (
    .I_CLK     (I_CLK),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .O_CLK     (O_CLK),
    .O_CLK_EN  (O_CLK_EN),
    .O_STATE   (O_STATE),
    .O_CYCLES  (O_CYCLES)
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic m_reset();
    m_mode = 0; m_div = 4; m_t = 0; m_stop = 0; m_cycles = 0;
    e_clk = 1'b0; e_en = 1'b0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    int p, tn;
    if (m_mode == 0) begin
      if (cfg_valid) m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
      if (step_req) begin
        m_mode = 2; m_t = 0; m_stop = 2 * m_div;
      end else if (run_req) begin
        m_mode = 1; m_t = 0;
      end
      e_clk = 1'b0; e_en = 1'b0;
    end else begin
      tn = m_t + 1;
      p  = 2 * m_div;
      e_en  = ((tn % p) == m_div);
      e_clk = ((tn % p) >= m_div);
      if (e_en) m_cycles = (m_cycles + 1) % 16;
      case (m_mode)
        1: if (halt_req) begin m_mode = 3; m_stop = (tn / p + 1) * p; end
        2: if (tn == m_stop) m_mode = 0; else if (halt_req) m_mode = 3;
        3: if (tn == m_stop) m_mode = 0;
        default: m_mode = 0;
      endcase
      m_t = tn;
    end
    @(posedge I_CLK);
    #1;
    cfg_valid = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  task automatic stop_run(input string nm);
    int k;
    halt_req = 1'b1;
    tick();
    k = 0;
    while (O_STATE !== 2'd0 && k < 64) begin
      tick();
      k++;
    end
    n_checks++;
    if (O_STATE !== 2'd0 || O_CLK !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_stop got state=%0d clk=%0b exp state=0 clk=0", nm, O_STATE, O_CLK);
    end
    n_checks++;
    if (O_CYCLES !== 4'(m_cycles)) begin
      n_errors++;
      $display("FAIL %s_cycles got=%0d exp=%0d", nm, O_CYCLES, m_cycles);
    end
    $display("txn %s: halted after %0d drain cycles, cycles=%0d", nm, k + 1, O_CYCLES);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    n_checks++;
    if (O_CLK !== 1'b0 || O_CLK_EN !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_clk got clk=%0b en=%0b exp 0 0", O_CLK, O_CLK_EN);
    end
    n_checks++;
    if (O_STATE !== 2'd0 || O_CYCLES !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_state got state=%0d cycles=%0d exp 0 0", O_STATE, O_CYCLES);
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready got=%0b exp=1", cfg_ready);
    end
    @(negedge I_CLK);
    rst = 1'b1;
    halt_req = 1'b1;
    tick();
    tick();
    n_checks++;
    if (O_STATE !== 2'd0 || O_CLK !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold got state=%0d clk=%0b exp 0 0", O_STATE, O_CLK);
    end
    $display("txn reset: released, holding in HALT");
  endtask

  task automatic test_run_basic();
    run_req = 1'b1;
    tick();
    n_checks++;
    if (O_STATE !== 2'd1 || cfg_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL run_enter got state=%0d ready=%0b exp 1 0", O_STATE, cfg_ready);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_checks++;
      if (O_CLK_EN !== (i == 4 || i == 12) || O_CLK !== ((i % 8) >= 4)) begin
        n_errors++;
        $display("FAIL run_wave edge=%0d got clk=%0b en=%0b exp clk=%0b en=%0b",
                 i, O_CLK, O_CLK_EN, (i % 8) >= 4, (i == 4 || i == 12));
      end
    end
    n_checks++;
    if (O_CYCLES !== 4'd2) begin
      n_errors++;
      $display("FAIL run_cycles got=%0d exp=2", O_CYCLES);
    end
    stop_run("run_basic");
  endtask

  task automatic test_step_cfg();
    int exp_cyc;
    cfg_valid = 1'b1; cfg_div = 32'd3;
    tick();
    exp_cyc = (m_cycles + 1) % 16;
    step_req = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (O_CLK_EN !== (i == 3) || O_CLK !== (i >= 3 && i <= 5)) begin
        n_errors++;
        $display("FAIL step_wave edge=%0d got clk=%0b en=%0b exp clk=%0b en=%0b",
                 i, O_CLK, O_CLK_EN, (i >= 3 && i <= 5), (i == 3));
      end
      n_checks++;
      if (O_STATE !== ((i == 6) ? 2'd0 : 2'd2) || cfg_ready !== (i == 6)) begin
        n_errors++;
        $display("FAIL step_state edge=%0d got state=%0d ready=%0b exp state=%0d ready=%0b",
                 i, O_STATE, cfg_ready, (i == 6) ? 0 : 2, (i == 6));
      end
    end
    n_checks++;
    if (O_CYCLES !== 4'(exp_cyc)) begin
      n_errors++;
      $display("FAIL step_cycles got=%0d exp=%0d", O_CYCLES, exp_cyc);
    end
    $display("txn step: div=3 single period, cycles=%0d", O_CYCLES);
  endtask

  task automatic test_halt_phases();
    cfg_valid = 1'b1; cfg_div = 32'd4;
    tick();
    run_req = 1'b1;
    tick();
    repeat (5) tick();
    halt_req = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      tick();
      n_checks++;
      if (O_CLK !== (i < 8) || O_STATE !== ((i < 8) ? 2'd3 : 2'd0)) begin
        n_errors++;
        $display("FAIL halt_high edge=%0d got clk=%0b state=%0d exp clk=%0b state=%0d",
                 i, O_CLK, O_STATE, (i < 8), (i < 8) ? 3 : 0);
      end
    end
    $display("txn halt while high: stopped at next fall");
    run_req = 1'b1;
    tick();
    repeat (9) tick();
    halt_req = 1'b1;
    tick();
    for (int i = 11; i <= 18; i++) begin
      tick();
      n_checks++;
      if (O_CLK !== (i >= 12 && i < 16) || O_CLK_EN !== (i == 12) ||
          O_STATE !== ((i < 16) ? 2'd3 : 2'd0)) begin
        n_errors++;
        $display("FAIL halt_low edge=%0d got clk=%0b en=%0b state=%0d exp clk=%0b en=%0b state=%0d",
                 i, O_CLK, O_CLK_EN, O_STATE, (i >= 12 && i < 16), (i == 12), (i < 16) ? 3 : 0);
      end
    end
    $display("txn halt while low: one more full period");
  endtask

  task automatic test_cfg_in_run();
    int first, second;
    run_req = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_div = 32'd7;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_run_ready got=%0b exp=0", cfg_ready);
    end
    tick();
    first = -1; second = -1;
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (O_CLK_EN === 1'b1) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    n_checks++;
    if (first != 4 || second - first != 8) begin
      n_errors++;
      $display("FAIL cfg_run_period got rises=%0d,%0d exp=4,12", first, second);
    end
    stop_run("cfg_in_run");
    cfg_valid = 1'b1; cfg_div = 32'd0;
    tick();
    run_req = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (O_CLK !== (i % 2 == 1) || O_CLK_EN !== (i % 2 == 1)) begin
        n_errors++;
        $display("FAIL div0_wave edge=%0d got clk=%0b en=%0b exp=%0b", i, O_CLK, O_CLK_EN, (i % 2 == 1));
      end
    end
    stop_run("div0");
  endtask

  task automatic test_wrap();
    int k;
    run_req = 1'b1;
    tick();
    k = 0;
    while (O_CYCLES !== 4'd15 && k < 64) begin
      tick();
      k++;
    end
    n_checks++;
    if (O_CYCLES !== 4'd15) begin
      n_errors++;
      $display("FAIL wrap_preset got=%0d exp=15", O_CYCLES);
    end
    tick();
    tick();
    n_checks++;
    if (O_CYCLES !== 4'd0 || O_CLK_EN !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_zero got cycles=%0d en=%0b exp cycles=0 en=1", O_CYCLES, O_CLK_EN);
    end
    stop_run("wrap");
  endtask

  task automatic test_step_priority();
    cfg_valid = 1'b1; cfg_div = 32'd2;
    step_req = 1'b1; run_req = 1'b1; halt_req = 1'b1;
    tick();
    n_checks++;
    if (O_STATE !== 2'd2) begin
      n_errors++;
      $display("FAIL prio_state got=%0d exp=2", O_STATE);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (O_CLK_EN !== (i == 2) || O_STATE !== ((i < 4) ? 2'd2 : 2'd0)) begin
        n_errors++;
        $display("FAIL prio_wave edge=%0d got en=%0b state=%0d exp en=%0b state=%0d",
                 i, O_CLK_EN, O_STATE, (i == 2), (i < 4) ? 2 : 0);
      end
    end
    $display("txn step+run+halt together: STEP taken with new div=2");
  endtask

  task automatic test_reset_mid_run();
    cfg_valid = 1'b1; cfg_div = 32'd3;
    tick();
    run_req = 1'b1;
    tick();
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (O_CLK !== 1'b0 || O_STATE !== 2'd0 || O_CYCLES !== 4'd0 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset got clk=%0b state=%0d cycles=%0d ready=%0b exp 0 0 0 1",
               O_CLK, O_STATE, O_CYCLES, cfg_ready);
    end
    m_reset();
    @(negedge I_CLK);
    rst = 1'b1;
    run_req = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (O_CLK_EN !== (i == 4)) begin
        n_errors++;
        $display("FAIL reset_div edge=%0d got en=%0b exp=%0b", i, O_CLK_EN, (i == 4));
      end
    end
    stop_run("reset_mid_run");
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      run_req   = ($urandom_range(0, 99) < 8);
      halt_req  = ($urandom_range(0, 99) < 5);
      step_req  = ($urandom_range(0, 99) < 6);
      cfg_valid = ($urandom_range(0, 99) < 20);
      cfg_div   = 32'($urandom_range(0, 5));
      if (m_mode == 0 && (run_req || step_req))
        $display("txn random %0d: start %s", n, step_req ? "step" : "run");
      tick();
      n_checks++;
      if (O_CLK !== e_clk || O_CLK_EN !== e_en) begin
        n_errors++;
        $display("FAIL rand_clk n=%0d got clk=%0b en=%0b exp clk=%0b en=%0b", n, O_CLK, O_CLK_EN, e_clk, e_en);
      end
      n_checks++;
      if (O_STATE !== 2'(m_mode) || cfg_ready !== (m_mode == 0)) begin
        n_errors++;
        $display("FAIL rand_state n=%0d got state=%0d ready=%0b exp state=%0d", n, O_STATE, cfg_ready, m_mode);
      end
      n_checks++;
      if (O_CYCLES !== 4'(m_cycles)) begin
        n_errors++;
        $display("FAIL rand_cycles n=%0d got=%0d exp=%0d", n, O_CYCLES, m_cycles);
      end
    end
  endtask

  initial begin
    cfg_valid = 1'b0; cfg_div = 32'd0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    m_reset();
    test_reset();
    test_run_basic();
    test_step_cfg();
    test_halt_phases();
    test_cfg_in_run();
    test_wrap();
    test_step_priority();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
